// File: rtl/mem_bank_router_if.sv
// Bundles the CPU request/response and memory-bank signals of mem_bank_router.
// Parameters must match those of the router instance the interface is bound to.
//   slave  : router view (takes requests and bank read data; drives strobes and responses)
//   master : environment view (CPU plus bank models)
interface mem_bank_router_if #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int BANK_ADDR_W = 15,
  parameter int NUM_BANKS   = 2
) ();
  logic                        req_valid;
  logic                        req_ready;
  logic                        req_we;
  logic [ADDR_W-1:0]           req_addr;
  logic [DATA_W-1:0]           req_wdata;
  logic [NUM_BANKS-1:0]        bank_en;
  logic                        bank_we;
  logic [BANK_ADDR_W-1:0]      bank_addr;
  logic [DATA_W-1:0]           bank_wdata;
  logic [NUM_BANKS*DATA_W-1:0] bank_rdata;
  logic                        rsp_valid;
  logic [DATA_W-1:0]           rsp_rdata;
  logic                        rsp_err;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, bank_rdata,
    output req_ready, bank_en, bank_we, bank_addr, bank_wdata,
           rsp_valid, rsp_rdata, rsp_err
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, bank_rdata,
    input  req_ready, bank_en, bank_we, bank_addr, bank_wdata,
           rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_bank_router.sv
// mem_bank_router: routes one CPU load/store at a time to one of NUM_BANKS
// memory banks selected by req_addr[ADDR_W-1:BANK_ADDR_W]. Issues a one-cycle
// one-hot bank strobe, waits RD_LAT cycles for reads, and returns a one-cycle
// registered response. Out-of-range bank indices answer with rsp_err and never
// touch a bank.
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   bus        mem_bank_router_if.slave (request, bank and response signals)
//   acc_count  per-bank 16-bit saturating access counters (stats build only)
//   err_count  16-bit saturating error counter (stats build only)
// Optional feature: define MEM_BANK_ROUTER_STATS_EN to add the access/error counters.
//
// state | meaning
// IDLE  | req_ready high, accept and latch a request
// ISSUE | one-cycle bank strobe for the latched request
// WAIT  | read latency countdown, capture read data when counter hits 0
// RESP  | one-cycle rsp_valid with registered data/err
module mem_bank_router #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int BANK_ADDR_W = 15,
  parameter int NUM_BANKS   = 2,
  parameter int RD_LAT      = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_bank_router_if.slave       bus
`ifdef MEM_BANK_ROUTER_STATS_EN
  ,
  output logic [NUM_BANKS*16-1:0] acc_count,
  output logic [15:0]             err_count
`endif
);
  localparam int IDX_W = ADDR_W - BANK_ADDR_W;
  // One extra bit so NUM_BANKS == 2**IDX_W is representable in the compare.
  localparam logic [IDX_W:0] NB_LIM   = (IDX_W+1)'(NUM_BANKS);
  localparam logic [2:0]     CNT_INIT = 3'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                 state_q, state_d;
  logic                   we_q, we_d;
  logic [BANK_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [DATA_W-1:0]      rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q, rsp_err_d;

  logic [IDX_W-1:0]       req_idx;
  logic                   req_in_range;
  logic [DATA_W-1:0]      rd_sel;
  logic                   issue;

  assign req_idx      = bus.req_addr[ADDR_W-1:BANK_ADDR_W];
  assign req_in_range = ({1'b0, req_idx} < NB_LIM);
  assign issue        = (state_q == ISSUE);

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (idx_q == IDX_W'(i)) rd_sel = bus.bank_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr[BANK_ADDR_W-1:0];
          wdata_d = bus.req_wdata;
          idx_d   = req_idx;
          if (req_in_range) begin
            state_d = ISSUE;
          end else begin
            state_d   = RESP;
            rsp_err_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          rsp_rdata_d = rd_sel;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        state_d     = IDLE;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Bank-side outputs are gated by ISSUE so they read 0 in every other state.
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.bank_en    = issue ? (NUM_BANKS'(1) << idx_q) : '0;
  assign bus.bank_we    = issue & we_q;
  assign bus.bank_addr  = issue ? addr_q : '0;
  assign bus.bank_wdata = issue ? wdata_q : '0;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_err    = rsp_err_q;

`ifdef MEM_BANK_ROUTER_STATS_EN
  logic [NUM_BANKS-1:0][15:0] acc_q, acc_d;
  logic [15:0]                err_q, err_d;

  always_comb begin
    acc_d = acc_q;
    err_d = err_q;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (issue && idx_q == IDX_W'(i) && acc_q[i] != 16'hFFFF) acc_d[i] = acc_q[i] + 16'd1;
    end
    if (state_q == IDLE && bus.req_valid && !req_in_range && err_q != 16'hFFFF)
      err_d = err_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      err_q <= '0;
    end else begin
      acc_q <= acc_d;
      err_q <= err_d;
    end
  end

  assign acc_count = acc_q;
  assign err_count = err_q;
`endif
endmodule

// File: tb/tb_mem_bank_router.sv
module tb_mem_bank_router;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // A: defaults (2 banks, RD_LAT=1). B: 3 banks, 14-bit bank address, RD_LAT=3.
  mem_bank_router_if #(.DATA_W(16), .ADDR_W(16), .BANK_ADDR_W(15), .NUM_BANKS(2)) ifa ();
  mem_bank_router_if #(.DATA_W(16), .ADDR_W(16), .BANK_ADDR_W(14), .NUM_BANKS(3)) ifb ();

`ifdef MEM_BANK_ROUTER_STATS_EN
  logic [31:0] acc_a;
  logic [15:0] err_a;
  logic [47:0] acc_b;
  logic [15:0] err_b;
`endif

  mem_bank_router #(.DATA_W(16), .ADDR_W(16), .BANK_ADDR_W(15), .NUM_BANKS(2), .RD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave)
`ifdef MEM_BANK_ROUTER_STATS_EN
    , .acc_count(acc_a), .err_count(err_a)
`endif
  );

  mem_bank_router #(.DATA_W(16), .ADDR_W(16), .BANK_ADDR_W(14), .NUM_BANKS(3), .RD_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave)
`ifdef MEM_BANK_ROUTER_STATS_EN
    , .acc_count(acc_b), .err_count(err_b)
`endif
  );

  // Bank models: read data is valid only in the RD_LAT-th cycle after the read strobe.
  logic       sr_a = 1'b0;
  logic [2:0] sr_b = 3'b000;
  always @(posedge clk) begin
    sr_a <= (|ifa.bank_en) & ~ifa.bank_we;
    sr_b <= {sr_b[1:0], (|ifb.bank_en) & ~ifb.bank_we};
  end
  assign ifa.bank_rdata = sr_a    ? {16'h1234, 16'h5678} : {2{16'hDEAD}};
  assign ifb.bank_rdata = sr_b[2] ? {16'h9ABC, 16'h1234, 16'h5678} : {3{16'hDEAD}};

  // Handshake monitors
  int acc_cnt_a = 0, rsp_cnt_a = 0, en_cnt_a = 0, viol_a = 0;
  int rsp_cnt_b = 0;
  always @(posedge clk) begin
    if (ifa.req_valid && ifa.req_ready) acc_cnt_a++;
    if (ifa.rsp_valid) rsp_cnt_a++;
    if (|ifa.bank_en) en_cnt_a++;
    if ((|ifa.bank_en || ifa.rsp_valid) && ifa.req_ready) viol_a++;
    if (ifb.rsp_valid) rsp_cnt_b++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req_a(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    ifa.req_valid = 1'b1; ifa.req_we = we; ifa.req_addr = addr; ifa.req_wdata = wdata;
    @(negedge clk);
    ifa.req_valid = 1'b0;
  endtask

  task automatic req_b(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    ifb.req_valid = 1'b1; ifb.req_we = we; ifb.req_addr = addr; ifb.req_wdata = wdata;
    @(negedge clk);
    ifb.req_valid = 1'b0;
  endtask

  task automatic wait_rsp_a(output int lat);
    lat = 1;
    while (ifa.rsp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_rsp_b(output int lat);
    lat = 1;
    while (ifb.rsp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int acc0, rsp0, en0, rspb0;
    logic alt;
    ifa.req_valid = 1'b0; ifa.req_we = 1'b0; ifa.req_addr = '0; ifa.req_wdata = '0;
    ifb.req_valid = 1'b0; ifb.req_we = 1'b0; ifb.req_addr = '0; ifb.req_wdata = '0;
    repeat (2) @(negedge clk);

    chk("reset_ready",  ifa.req_ready, 1'b1);
    chk("reset_en",     ifa.bank_en, 2'b00);
    chk("reset_rvalid", ifa.rsp_valid, 1'b0);
    chk("reset_rdata",  ifa.rsp_rdata, 16'h0000);
    chk("reset_err",    ifa.rsp_err, 1'b0);
    chk("reset_baddr",  ifa.bank_addr, 15'h0000);
    rst = 1'b0;
    @(negedge clk);

    // Write to bank 0
    req_a(1'b1, 16'h0010, 16'hABCD);
    chk("wr_en",     ifa.bank_en, 2'b01);
    chk("wr_we",     ifa.bank_we, 1'b1);
    chk("wr_addr",   ifa.bank_addr, 15'h0010);
    chk("wr_wdata",  ifa.bank_wdata, 16'hABCD);
    chk("wr_ready",  ifa.req_ready, 1'b0);
    wait_rsp_a(lat);
    chk("wr_lat",    lat, 2);
    chk("wr_err",    ifa.rsp_err, 1'b0);
    chk("wr_rdata",  ifa.rsp_rdata, 16'h0000);
    chk("wr_en_off", ifa.bank_en, 2'b00);
    @(negedge clk);
    chk("wr_idle",   ifa.req_ready, 1'b1);
    chk("wr_rv_off", ifa.rsp_valid, 1'b0);

    // Read from bank 1, RD_LAT=1
    req_a(1'b0, 16'h8004, 16'h0000);
    chk("rd1_en",    ifa.bank_en, 2'b10);
    chk("rd1_we",    ifa.bank_we, 1'b0);
    chk("rd1_addr",  ifa.bank_addr, 15'h0004);
    wait_rsp_a(lat);
    chk("rd1_lat",   lat, 3);
    chk("rd1_rdata", ifa.rsp_rdata, 16'h1234);
    chk("rd1_err",   ifa.rsp_err, 1'b0);
    @(negedge clk);
    chk("rd1_clr",   ifa.rsp_rdata, 16'h0000);

    // Read from bank 0
    req_a(1'b0, 16'h0002, 16'h0000);
    chk("rd0_en",    ifa.bank_en, 2'b01);
    wait_rsp_a(lat);
    chk("rd0_lat",   lat, 3);
    chk("rd0_rdata", ifa.rsp_rdata, 16'h5678);
    @(negedge clk);

    // RD_LAT=3 read of bank 1 on B
    req_b(1'b0, 16'h4004, 16'h0000);
    chk("rd3_en",    ifb.bank_en, 3'b010);
    chk("rd3_addr",  ifb.bank_addr, 14'h0004);
    wait_rsp_b(lat);
    chk("rd3_lat",   lat, 5);
    chk("rd3_rdata", ifb.rsp_rdata, 16'h1234);
    @(negedge clk);

    // Bank 2 on B
    req_b(1'b0, 16'h8000, 16'h0000);
    chk("rd3b2_en",  ifb.bank_en, 3'b100);
    wait_rsp_b(lat);
    chk("rd3b2_lat", lat, 5);
    chk("rd3b2_rdata", ifb.rsp_rdata, 16'h9ABC);
    @(negedge clk);

    // Out-of-range index 3 on B
    req_b(1'b0, 16'hC000, 16'h0000);
    chk("err_en",    ifb.bank_en, 3'b000);
    wait_rsp_b(lat);
    chk("err_lat",   lat, 1);
    chk("err_err",   ifb.rsp_err, 1'b1);
    chk("err_rdata", ifb.rsp_rdata, 16'h0000);
    @(negedge clk);
    chk("err_clr",   ifb.rsp_err, 1'b0);
    chk("err_ready", ifb.req_ready, 1'b1);

    // Continuous req_valid with alternating write/read: 4 accepts in 14 cycles
    acc0 = acc_cnt_a; rsp0 = rsp_cnt_a; en0 = en_cnt_a;
    alt = 1'b1;
    ifa.req_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (ifa.req_ready) begin
        ifa.req_we    = alt;
        ifa.req_addr  = alt ? 16'h0020 : 16'h8004;
        ifa.req_wdata = 16'h5A5A;
        alt = ~alt;
      end
      @(negedge clk);
    end
    ifa.req_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("hold_accepts", acc_cnt_a - acc0, 4);
    chk("hold_rsps",    rsp_cnt_a - rsp0, 4);
    chk("hold_strobes", en_cnt_a - en0, 4);
    chk("hold_viol",    viol_a, 0);

    // Reset during WAIT of a read on B
    req_b(1'b0, 16'h4004, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    rspb0 = rsp_cnt_b;
    @(negedge clk);
    chk("rst_ready", ifb.req_ready, 1'b1);
    chk("rst_en",    ifb.bank_en, 3'b000);
    chk("rst_we",    ifb.bank_we, 1'b0);
    chk("rst_rv",    ifb.rsp_valid, 1'b0);
    chk("rst_rdata", ifb.rsp_rdata, 16'h0000);
    chk("rst_err",   ifb.rsp_err, 1'b0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_no_rsp", rsp_cnt_b - rspb0, 0);

`ifdef MEM_BANK_ROUTER_STATS_EN
    chk("st_zero_acc", acc_b, 48'h0);
    req_b(1'b1, 16'h0001, 16'h1111); wait_rsp_b(lat); @(negedge clk);
    req_b(1'b0, 16'h0002, 16'h0000); wait_rsp_b(lat); @(negedge clk);
    req_b(1'b1, 16'h0003, 16'h2222); wait_rsp_b(lat); @(negedge clk);
    req_b(1'b1, 16'h4000, 16'h3333); wait_rsp_b(lat); @(negedge clk);
    req_b(1'b0, 16'hC000, 16'h0000); wait_rsp_b(lat); @(negedge clk);
    chk("st_acc", acc_b, 48'h0000_0001_0003);
    chk("st_err", err_b, 16'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("st_acc_rst", acc_b, 48'h0);
    chk("st_err_rst", err_b, 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
